// File: rtl/clic_pkg.sv
// Shared types and defaults for the CLIC interrupt gateway.
// Trigger encoding matches the attr_trig register field: bit 0 = edge, bit 1 = negative.
package clic_pkg;

  typedef enum logic [1:0] {
    TRIG_LVL_POS  = 2'b00,
    TRIG_EDGE_POS = 2'b01,
    TRIG_LVL_NEG  = 2'b10,
    TRIG_EDGE_NEG = 2'b11
  } clic_trig_e;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int N_SOURCE_DEFAULT    = 256;

  // Claim index width; a single source still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clic_gateway_if.sv
// Register-file / core side of the gateway: software pending writes, claims,
// overrun clears in; pending bits, write-back strobes and overrun flags out.
interface clic_gateway_if
  import clic_pkg::*;
#(
  parameter int N_SOURCE    = N_SOURCE_DEFAULT,
  parameter int SrcIdxWidth = idx_width(N_SOURCE)
);

  logic [N_SOURCE-1:0]    sw_ip_we_i;
  logic [N_SOURCE-1:0]    sw_ip_wdata_i;
  logic                   claim_valid_i;
  logic [SrcIdxWidth-1:0] claim_id_i;
  logic [N_SOURCE-1:0]    ovf_clr_i;
  logic [N_SOURCE-1:0]    ip_o;
  logic [N_SOURCE-1:0]    ip_de_o;
  logic [N_SOURCE-1:0]    ip_d_o;
  logic [N_SOURCE-1:0]    ovf_o;

  modport master (
    output sw_ip_we_i, sw_ip_wdata_i, claim_valid_i, claim_id_i, ovf_clr_i,
    input  ip_o, ip_de_o, ip_d_o, ovf_o
  );

  modport slave (
    input  sw_ip_we_i, sw_ip_wdata_i, claim_valid_i, claim_id_i, ovf_clr_i,
    output ip_o, ip_de_o, ip_d_o, ovf_o
  );

endinterface

// File: rtl/clic_gateway_src.sv
// One interrupt source: synchroniser, raw sample register, edge detect,
// hardware-managed pending bit and sticky overrun flag.
module clic_gateway_src
  import clic_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       src_i,
  input  logic [1:0] trig_i,
  input  logic       sw_we_i,
  input  logic       sw_wdata_i,
  input  logic       claim_i,
  input  logic       ovf_clr_i,
  output logic       ip_o,
  output logic       ip_de_o,
  output logic       ip_d_o,
  output logic       ovf_o
);

  clic_trig_e trig;
  logic       s;
  logic       is_edge;
  logic       neg;
  logic       lvl;
  logic       p_lvl;
  logic       edge_evt;
  logic       clr_evt;
  logic       p_q, p_d;
  logic       ip_q, ip_d;
  logic       ovf_q, ovf_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = src_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
      sync_d = (sync_q << 1) | SYNC_STAGES'(src_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    trig    = clic_trig_e'(trig_i);
    is_edge = (trig == TRIG_EDGE_POS) || (trig == TRIG_EDGE_NEG);
    neg     = (trig == TRIG_LVL_NEG)  || (trig == TRIG_EDGE_NEG);

    // p holds the raw sample; polarity is applied only here, so flipping
    // the polarity bit on a stable line never looks like an edge.
    lvl      = s ^ neg;
    p_lvl    = p_q ^ neg;
    edge_evt = is_edge & lvl & ~p_lvl;
    clr_evt  = claim_i | (sw_we_i & ~sw_wdata_i);
    p_d      = s;

    ip_d = ip_q;
    if (!is_edge) begin
      ip_d = lvl;
    end else if (edge_evt) begin
      ip_d = 1'b1;
    end else if (sw_we_i) begin
      ip_d = sw_wdata_i;
    end else if (claim_i) begin
      ip_d = 1'b0;
    end

    // An edge that coincides with a clear is absorbed by the pending bit,
    // so it is not counted as lost.
    ovf_d = ovf_q;
    if (edge_evt && ip_q && !clr_evt) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q   <= 1'b0;
      ip_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      ip_q  <= ip_d;
      ovf_q <= ovf_d;
    end
  end

  assign ip_o    = ip_q;
  assign ovf_o   = ovf_q;
  // Write-back is masked in reset so negative-level sources do not strobe.
  assign ip_d_o  = ~rst_i & ip_d;
  assign ip_de_o = ~rst_i & (ip_d ^ ip_q);

endmodule

// File: rtl/clic_gateway.sv
// CLIC interrupt gateway top: decodes the claim index to one-hot and
// instantiates one gateway slice per interrupt source.
module clic_gateway
  import clic_pkg::*;
#(
  parameter int N_SOURCE    = N_SOURCE_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int SrcIdxWidth = idx_width(N_SOURCE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_SOURCE-1:0]   src_i,
  input  logic [2*N_SOURCE-1:0] trig_i,
  clic_gateway_if.slave         rf
);

  logic [SrcIdxWidth-1:0] claim_id;
  logic [N_SOURCE-1:0]    claim_oh;
  logic [N_SOURCE-1:0]    ip;
  logic [N_SOURCE-1:0]    ip_de;
  logic [N_SOURCE-1:0]    ip_d;
  logic [N_SOURCE-1:0]    ovf;

  assign claim_id = rf.claim_id_i;

  // Indices at or beyond N_SOURCE match no slice and are thereby ignored.
  always_comb begin
    claim_oh = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      claim_oh[i] = rf.claim_valid_i && (int'(claim_id) == i);
    end
  end

  for (genvar gi = 0; gi < N_SOURCE; gi++) begin : g_src
    clic_gateway_src #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_src (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .src_i      (src_i[gi]),
      .trig_i     (trig_i[2*gi +: 2]),
      .sw_we_i    (rf.sw_ip_we_i[gi]),
      .sw_wdata_i (rf.sw_ip_wdata_i[gi]),
      .claim_i    (claim_oh[gi]),
      .ovf_clr_i  (rf.ovf_clr_i[gi]),
      .ip_o       (ip[gi]),
      .ip_de_o    (ip_de[gi]),
      .ip_d_o     (ip_d[gi]),
      .ovf_o      (ovf[gi])
    );
  end

  assign rf.ip_o    = ip;
  assign rf.ip_de_o = ip_de;
  assign rf.ip_d_o  = ip_d;
  assign rf.ovf_o   = ovf;

endmodule
